// File: rtl/guess_player.sv
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// guess_player
//
// Purpose:
//   Automatic player for the Decision comparator. It finds the hidden
//   Correct_guess value by binary search. Each guess goes out on In_wr, and
//   the player waits for Decision's Result feedback before narrowing the
//   [lo, hi] search window.
//
// Configuration:
//   GUESS_TIMEOUT_EN (macro) - when defined, a WAIT state that has seen
//   Result=00 for TIMEOUT cycles ends the game in FAIL. When undefined, no
//   timer is built and WAIT waits indefinitely for a response.
//
// Parameters:
//   WIDTH   - guess width; must match Decision In_wr / Correct_guess.
//   TIMEOUT - WAIT cycles without a response before FAIL (timeout build only).
//
// Ports:
//   clk          in   system clock, rising edge
//   Reset        in   synchronous active-low reset
//   start        in   begin a new game (sampled in IDLE, DONE, FAIL)
//   Result[1:0]  in   00 none, 01 too low, 10 too high, 11 correct
//   In_wr        out  current guess to Decision
//   guess_valid  out  high in GUESS and WAIT
//   done         out  game won, held until restart
//   fail         out  contradiction or timeout, held until restart
//   found        out  winning guess, valid while done=1
//   attempts     out  guesses issued in the current game (WIDTH+1 bits)
//------------------------------------------------------------------------------
module guess_player #(
    parameter int WIDTH   = 2,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [1:0]       Result,
    output logic [WIDTH-1:0] In_wr,
    output logic             guess_valid,
    output logic             done,
    output logic             fail,
    output logic [WIDTH-1:0] found,
    output logic [WIDTH:0]   attempts
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GUESS,
        S_WAIT,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [WIDTH-1:0] MAX_VAL = '1;
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
    localparam logic [WIDTH:0]   ONE_A   = (WIDTH+1)'(1);
    localparam logic [WIDTH:0]   MAX_ATT = '1;

    state_t           r_state;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_in_wr;
    logic             r_guess_valid;
    logic             r_done;
    logic             r_fail;
    logic [WIDTH-1:0] r_found;
    logic [WIDTH:0]   r_attempts;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_mid;
    logic [WIDTH-1:0] w_in_inc;
    logic [WIDTH-1:0] w_in_dec;
    logic [WIDTH:0]   w_att_next;

    // The sum is one bit wider than the bounds, so (lo+hi)>>1 cannot overflow.
    assign w_sum      = {1'b0, r_lo} + {1'b0, r_hi};
    assign w_mid      = WIDTH'(w_sum >> 1);
    // These wrap only at the boundary values, and those cases are sent to
    // FAIL before either result is used.
    assign w_in_inc   = r_in_wr + ONE_W;
    assign w_in_dec   = r_in_wr - ONE_W;
    // The counter saturates. A consistent responder needs at most WIDTH+1
    // guesses, so this only protects against a misbehaving partner.
    assign w_att_next = (r_attempts == MAX_ATT) ? r_attempts : r_attempts + ONE_A;

`ifdef GUESS_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] ONE_T      = TW'(1);
    logic [TW-1:0] r_timer;
`else
    // TIMEOUT has no effect in this build; it is folded into a dead wire so
    // the parameter list stays the same in both builds.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
`endif

    // NOTE: all state is updated with non-blocking assignments. Every branch
    // below reads the values from before the edge, so the order of statements
    // inside a branch does not matter.
    always_ff @(posedge clk) begin
        // NOTE: the reset is synchronous and clears every register, including
        // the search bounds. A reset taken mid-WAIT therefore never leaves a
        // half-updated window behind.
        if (!Reset) begin
            r_state       <= S_IDLE;
            r_lo          <= '0;
            r_hi          <= '0;
            r_in_wr       <= '0;
            r_guess_valid <= 1'b0;
            r_done        <= 1'b0;
            r_fail        <= 1'b0;
            r_found       <= '0;
            r_attempts    <= '0;
`ifdef GUESS_TIMEOUT_EN
            r_timer       <= '0;
`endif
        end else begin
            case (r_state)
                // A new game can start from idle or from either end state.
                // Restarting also clears the previous outcome.
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        r_lo          <= '0;
                        r_hi          <= MAX_VAL;
                        r_attempts    <= '0;
                        r_done        <= 1'b0;
                        r_fail        <= 1'b0;
                        r_found       <= '0;
                        r_guess_valid <= 1'b1;
                        r_state       <= S_GUESS;
                    end
                end

                // Result is ignored here: it still answers the previous guess.
                S_GUESS: begin
                    r_in_wr    <= w_mid;
                    r_attempts <= w_att_next;
`ifdef GUESS_TIMEOUT_EN
                    r_timer    <= '0;
`endif
                    r_state    <= S_WAIT;
                end

                S_WAIT: begin
                    case (Result)
                        2'b11: begin
                            r_found       <= r_in_wr;
                            r_done        <= 1'b1;
                            r_guess_valid <= 1'b0;
                            r_state       <= S_DONE;
                        end
                        // Too low: the new window is [in_wr+1, hi]. It is
                        // empty if in_wr is already the largest value or if
                        // in_wr+1 > hi.
                        2'b01: begin
                            if (r_in_wr == MAX_VAL || w_in_inc > r_hi) begin
                                r_fail        <= 1'b1;
                                r_guess_valid <= 1'b0;
                                r_state       <= S_FAIL;
                            end else begin
                                r_lo    <= w_in_inc;
                                r_state <= S_GUESS;
                            end
                        end
                        // Too high: the new window is [lo, in_wr-1]. It is
                        // empty if in_wr is zero or if in_wr-1 < lo.
                        2'b10: begin
                            if (r_in_wr == '0 || w_in_dec < r_lo) begin
                                r_fail        <= 1'b1;
                                r_guess_valid <= 1'b0;
                                r_state       <= S_FAIL;
                            end else begin
                                r_hi    <= w_in_dec;
                                r_state <= S_GUESS;
                            end
                        end
                        default: begin
`ifdef GUESS_TIMEOUT_EN
                            // The timer reads TIMEOUT-1 during the TIMEOUT-th
                            // silent WAIT cycle, so the game gives up on that
                            // edge.
                            if (r_timer == TIMER_LAST) begin
                                r_fail        <= 1'b1;
                                r_guess_valid <= 1'b0;
                                r_state       <= S_FAIL;
                            end else begin
                                r_timer <= r_timer + ONE_T;
                            end
`endif
                        end
                    endcase
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign In_wr       = r_in_wr;
    assign guess_valid = r_guess_valid;
    assign done        = r_done;
    assign fail        = r_fail;
    assign found       = r_found;
    assign attempts    = r_attempts;

endmodule

// File: tb/tb_guess_player.sv
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// tb_guess_player
//
// Directed bench for guess_player with WIDTH=2 and TIMEOUT=8. The bench plays
// the Decision comparator by hand. Each guess gets one silent cycle
// (Result=00) and then the scripted response. Inputs change on the falling
// edge, and outputs are sampled on the falling edge.
//------------------------------------------------------------------------------
module tb_guess_player;

    localparam int WIDTH = 2;

    logic             clk = 1'b0;
    logic             Reset;
    logic             start;
    logic [1:0]       Result;
    logic [WIDTH-1:0] In_wr;
    logic             guess_valid;
    logic             done;
    logic             fail;
    logic [WIDTH-1:0] found;
    logic [WIDTH:0]   attempts;

    int n_tests = 0;
    int n_fail  = 0;

    guess_player #(.WIDTH(WIDTH), .TIMEOUT(8)) dut (
        .clk         (clk),
        .Reset       (Reset),
        .start       (start),
        .Result      (Result),
        .In_wr       (In_wr),
        .guess_valid (guess_valid),
        .done        (done),
        .fail        (fail),
        .found       (found),
        .attempts    (attempts)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the end-of-game outputs in one call.
    task automatic check_end(input string tag, input logic e_done, input logic e_fail,
                             input logic [WIDTH-1:0] e_found, input logic [WIDTH:0] e_att);
        check({tag, ".done"},     32'(done),        32'(e_done));
        check({tag, ".fail"},     32'(fail),        32'(e_fail));
        check({tag, ".found"},    32'(found),       32'(e_found));
        check({tag, ".attempts"}, 32'(attempts),    32'(e_att));
        check({tag, ".valid"},    32'(guess_valid), 32'd0);
    endtask

    // Pulses start for one edge and checks that guess_valid rises one cycle
    // after start is sampled. On return the DUT is in GUESS.
    task automatic do_start(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".start_valid"}, 32'(guess_valid), 32'd1);
        check({tag, ".start_done"},  32'(done),        32'd0);
        check({tag, ".start_fail"},  32'(fail),        32'd0);
    endtask

    // Must be entered with the DUT in GUESS. The DUT moves to WAIT, where the
    // bench checks the guess, gives one silent cycle, and then answers with
    // resp.
    task automatic attempt(input string tag, input logic [WIDTH-1:0] e_guess,
                           input logic [WIDTH:0] e_att, input logic [1:0] resp);
        Result = 2'b00;
        @(negedge clk);
        check({tag, ".guess"},    32'(In_wr),    32'(e_guess));
        check({tag, ".attempts"}, 32'(attempts), 32'(e_att));
        @(negedge clk);
        check({tag, ".hold"},     32'(In_wr),    32'(e_guess));
        Result = resp;
        @(negedge clk);
        Result = 2'b00;
    endtask

    initial begin
        Reset  = 1'b0;
        start  = 1'b0;
        Result = 2'b00;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst.in_wr", 32'(In_wr),       32'd0);
        check("rst.valid", 32'(guess_valid), 32'd0);
        check_end("rst", 1'b0, 1'b0, 2'd0, 3'd0);
        Reset = 1'b1;
        @(negedge clk);
        check("idle.no_start", 32'(guess_valid), 32'd0);

        // Secret 00: guess 01 is too high, then guess 00 is correct.
        do_start("s00");
        attempt("s00.a1", 2'd1, 3'd1, 2'b10);
        attempt("s00.a2", 2'd0, 3'd2, 2'b11);
        check_end("s00", 1'b1, 1'b0, 2'd0, 3'd2);
        repeat (3) @(negedge clk);
        check("s00.hold_done", 32'(done),  32'd1);
        check("s00.hold_in",   32'(In_wr), 32'd0);

        // Secret 11: restarting from DONE clears the old result.
        do_start("s11");
        check("s11.cleared_found", 32'(found),    32'd0);
        check("s11.cleared_att",   32'(attempts), 32'd0);
        attempt("s11.a1", 2'd1, 3'd1, 2'b01);
        attempt("s11.a2", 2'd2, 3'd2, 2'b01);
        attempt("s11.a3", 2'd3, 3'd3, 2'b11);
        check_end("s11", 1'b1, 1'b0, 2'd3, 3'd3);

        // Secret 01: the first guess is correct, and a restart clears done on
        // the next cycle.
        do_start("s01");
        attempt("s01.a1", 2'd1, 3'd1, 2'b11);
        check_end("s01", 1'b1, 1'b0, 2'd1, 3'd1);
        do_start("s01.restart");

        // Inconsistent responder: 01 too high, then 00 too low gives lo=1 > hi=0.
        attempt("inc.a1", 2'd1, 3'd1, 2'b10);
        attempt("inc.a2", 2'd0, 3'd2, 2'b01);
        check_end("inc", 1'b0, 1'b1, 2'd0, 3'd2);
        check("inc.hold_in", 32'(In_wr), 32'd0);

        // "Too low" at the top value has nowhere left to go.
        do_start("top");
        check("top.fail_cleared", 32'(fail), 32'd0);
        attempt("top.a1", 2'd1, 3'd1, 2'b01);
        attempt("top.a2", 2'd2, 3'd2, 2'b01);
        attempt("top.a3", 2'd3, 3'd3, 2'b01);
        check_end("top", 1'b0, 1'b1, 2'd0, 3'd3);

        // "Too high" at zero has nowhere left to go.
        do_start("bot");
        attempt("bot.a1", 2'd1, 3'd1, 2'b10);
        attempt("bot.a2", 2'd0, 3'd2, 2'b10);
        check_end("bot", 1'b0, 1'b1, 2'd0, 3'd2);

        // Reset in WAIT after one attempt returns every output to zero.
        do_start("mid");
        Result = 2'b00;
        @(negedge clk);
        check("mid.wait_att", 32'(attempts), 32'd1);
        Reset = 1'b0;
        @(negedge clk);
        check("mid.rst_in",    32'(In_wr),       32'd0);
        check("mid.rst_valid", 32'(guess_valid), 32'd0);
        check_end("mid.rst", 1'b0, 1'b0, 2'd0, 3'd0);
        Reset = 1'b1;
        @(negedge clk);
        check("mid.idle", 32'(guess_valid), 32'd0);
        do_start("mid.new");
        attempt("mid.a1", 2'd1, 3'd1, 2'b11);
        check_end("mid.new", 1'b1, 1'b0, 2'd1, 3'd1);

        // Silent comparator: Result is held at 00 throughout.
        do_start("to");
        Result = 2'b00;
        @(negedge clk);
        check("to.guess", 32'(In_wr), 32'd1);
`ifdef GUESS_TIMEOUT_EN
        repeat (7) @(negedge clk);
        check("to.before", 32'(fail), 32'd0);
        @(negedge clk);
        check_end("to", 1'b0, 1'b1, 2'd0, 3'd1);
`else
        repeat (50) @(negedge clk);
        check("to.no_fail",  32'(fail),        32'd0);
        check("to.waiting",  32'(guess_valid), 32'd1);
        check("to.no_done",  32'(done),        32'd0);
`endif
        // start is ignored while the game is in WAIT.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef GUESS_TIMEOUT_EN
        check("to.restart_att", 32'(attempts), 32'd0);
`else
        check("to.start_ignored", 32'(attempts), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Backstop so the run always ends even if the sequence above stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
